// File: rtl/lift_pkg.sv
// Shared types and default constants for the SCAN lift controller.
// Provides state/direction enums and default parameter values.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DWELL
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam int DEF_NUM_FLOORS  = 8;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by travel and door-dwell timing.
// Ports: clk, reset_n, load, value (reload count), done (last cycle of count).
module lift_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A load of N expires on the N-th cycle after the load edge.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/lift_ctrl_scan.sv
// Multi-floor SCAN lift controller: latches calls, serves them in sweep order.
// Ports: clk, reset_n, call[NUM_FLOORS], door_hold (only with LIFT_DOOR_HOLD_EN),
// floor, door, up, down, stop, pending (all outputs registered).
import lift_pkg::*;

module lift_ctrl_scan #(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FLOOR_W-1:0]    floor,
  output logic                  door,
  output logic                  up,
  output logic                  down,
  output logic                  stop,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ?
                        MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic                    door_q, up_q, down_q, stop_q;

  logic                    tmr_load;
  logic [TW-1:0]           tmr_val;
  logic                    tmr_done;
  logic                    hold;

  logic [NUM_FLOORS-1:0]   pc;
  logic [NUM_FLOORS-1:0]   cur_bit, nxt_bit;
  logic [FLOOR_W-1:0]      nxt_floor;
  logic                    above, below;
  logic                    ahead, behind, at_end;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  lift_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .done    (tmr_done)
  );

  // Fresh calls join the decision in the same cycle they arrive.
  assign pc        = pend_q | call;
  assign cur_bit   = ONE << floor_q;
  assign nxt_floor = (dir_q == DIR_UP) ? floor_q + 1'b1
                                       : floor_q - 1'b1;
  assign nxt_bit   = ONE << nxt_floor;
  assign at_end    = (dir_q == DIR_UP) ?
                     (floor_q == FLOOR_W'(NUM_FLOORS - 1)) :
                     (floor_q == '0);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_q) above = above | pc[i];
      if (FLOOR_W'(i) < floor_q) below = below | pc[i];
    end
  end

  assign ahead  = (dir_q == DIR_UP) ? above : below;
  assign behind = (dir_q == DIR_UP) ? below : above;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    pend_d   = pc;
    tmr_load = 1'b0;
    tmr_val  = MOVE_LD;
    unique case (state_q)
      IDLE: begin
        pend_d = pc & ~cur_bit;
        if (pc[floor_q]) begin
          state_d  = DWELL;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
        end else if (ahead) begin
          state_d  = MOVE;
          tmr_load = 1'b1;
        end else if (behind) begin
          state_d  = MOVE;
          dir_d    = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          tmr_load = 1'b1;
        end
      end
      MOVE: begin
        if (tmr_done) begin
          if (at_end) begin
            // Unreachable with a sane pending map; keeps floor in range.
            state_d = IDLE;
          end else begin
            floor_d  = nxt_floor;
            tmr_load = 1'b1;
            if ((pc & nxt_bit) != '0) begin
              pend_d  = pc & ~nxt_bit;
              state_d = DWELL;
              tmr_val = DOOR_LD;
            end
          end
        end
      end
      DWELL: begin
        pend_d = pc & ~cur_bit;
        if (call[floor_q] || hold) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
        end else if (tmr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      pend_q  <= '0;
      door_q  <= 1'b1;
      stop_q  <= 1'b1;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      door_q  <= (state_d != MOVE);
      stop_q  <= (state_d != MOVE);
      up_q    <= (state_d == MOVE) && (dir_d == DIR_UP);
      down_q  <= (state_d == MOVE) && (dir_d == DIR_DOWN);
    end
  end

  assign floor   = floor_q;
  assign door    = door_q;
  assign up      = up_q;
  assign down    = down_q;
  assign stop    = stop_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_lift_ctrl_scan.sv
// Scoreboard bench for lift_ctrl_scan against a floor-by-floor reference model.
// Driver issues calls at negedge and queues expectations; monitor checks after posedge.
module tb_lift_ctrl_scan;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int MC = 4;
  localparam int DC = 8;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NF-1:0] call = '0;
`ifdef LIFT_DOOR_HOLD_EN
  logic          door_hold = 1'b0;
`endif
  logic [FW-1:0] floor;
  logic          door, up, down, stop;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  lift_ctrl_scan #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .call      (call),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .floor     (floor),
    .door      (door),
    .up        (up),
    .down      (down),
    .stop      (stop),
    .pending   (pending)
  );

  typedef struct packed {
    logic [FW-1:0] fl;
    logic          dr;
    logic          u;
    logic          dn;
    logic          st;
    logic [NF-1:0] pd;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: car position, travel sign, activity, cycles left.
  int   m_floor;
  int   m_dir;
  bit   m_moving;
  bit   m_open;
  int   m_left;
  bit   m_pend[NF];

  function automatic void model_reset();
    m_floor  = 0;
    m_dir    = 1;
    m_moving = 0;
    m_open   = 0;
    m_left   = 0;
    for (int i = 0; i < NF; i++) m_pend[i] = 0;
  endfunction

  function automatic bit any_side(int d);
    for (int f = m_floor + d; f >= 0 && f < NF; f += d)
      if (m_pend[f]) return 1;
    return 0;
  endfunction

  function automatic void model_step(logic [NF-1:0] c, bit h);
    for (int i = 0; i < NF; i++) if (c[i]) m_pend[i] = 1;
    if (m_moving) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_dir;
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 0;
          m_moving = 0;
          m_open = 1;
          m_left = DC;
        end else begin
          m_left = MC;
        end
      end
    end else if (m_open) begin
      m_pend[m_floor] = 0;
      if (c[m_floor] || h) begin
        m_left = DC;
      end else begin
        m_left--;
        if (m_left == 0) m_open = 0;
      end
    end else begin
      if (m_pend[m_floor]) begin
        m_pend[m_floor] = 0;
        m_open = 1;
        m_left = DC;
      end else if (any_side(m_dir)) begin
        m_moving = 1;
        m_left = MC;
      end else if (any_side(-m_dir)) begin
        m_dir = -m_dir;
        m_moving = 1;
        m_left = MC;
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t r;
    r.fl = 3'(m_floor);
    r.dr = !m_moving;
    r.st = !m_moving;
    r.u  = m_moving && (m_dir > 0);
    r.dn = m_moving && (m_dir < 0);
    for (int i = 0; i < NF; i++) r.pd[i] = m_pend[i];
    return r;
  endfunction

  function automatic obs_t act();
    obs_t r;
    r = '{fl: floor, dr: door, u: up, dn: down, st: stop, pd: pending};
    return r;
  endfunction

  task automatic check(string nm, obs_t a, obs_t e);
    checks++;
    if (a === e) begin
      passes++;
    end else begin
      $display("FAIL %s t=%0t: got fl=%0d door=%b up=%b dn=%b stop=%b pend=%b want fl=%0d door=%b up=%b dn=%b stop=%b pend=%b",
               nm, $time, a.fl, a.dr, a.u, a.dn, a.st, a.pd,
               e.fl, e.dr, e.u, e.dn, e.st, e.pd);
    end
  endtask

  // Monitor: one expected observation per clock edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", act(), e);
      end
    end
  end

  // Driver + reference model.
  initial begin
    int            rst_cnt;
    int            n_resets;
    int            r;
    bit            h;
    logic [NF-1:0] c;
    rst_cnt  = 0;
    n_resets = 0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check("reset", act(), model_obs());

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (!reset_n && rst_cnt > 0) begin
        rst_cnt--;
        call = '0;
        model_reset();
        exp_q.push_back(model_obs());
      end else if (reset_n && m_moving && n_resets < 3 &&
                   cyc > 200 && ($urandom % 150) == 0) begin
        n_resets++;
        call    = '0;
        reset_n = 1'b0;
        model_reset();
        #1 check("async_reset", act(), model_obs());
        rst_cnt = 2;
        exp_q.push_back(model_obs());
      end else begin
        reset_n = 1'b1;
        h = 1'b0;
        if (cyc < 120) begin
          // Directed: trip to 5, restarted dwell at 5, then trip to 2.
          case (cyc)
            0:       c = 8'b0010_0000;
            60, 64:  c = 8'b0010_0000;
            90:      c = 8'b0000_0100;
            default: c = '0;
          endcase
        end else begin
          r = int'($urandom % 100);
          if (r < 6)      c = NF'(1) << ($urandom % NF);
          else if (r < 8) c = NF'($urandom);
          else            c = '0;
`ifdef LIFT_DOOR_HOLD_EN
          h = (($urandom % 4) == 0);
`endif
        end
        call = c;
`ifdef LIFT_DOOR_HOLD_EN
        door_hold = h;
`endif
        model_step(c, h);
        exp_q.push_back(model_obs());
      end
    end

    @(negedge clk);
    call = '0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d queued want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
